hazard_sched: RTL and testbench

Pipeline hazard scheduler for the 16-bit five-stage core. It sits beside the ID stage, keeps a two-entry scoreboard of destinations in flight in EXE and MEM, and drives `hazard_detected` into ID. It also sequences stalls (PC/IF-ID freeze plus ID/EXE bubble) and taken-branch/jump flushes of IF/ID, and keeps saturating stall and flush event counters.

---
 rtl/hazard_sched.sv | 150 +++++++++++++++
 tb/tb_hazard_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 16-bit five-stage core: EXE/MEM destination scoreboard,
// RAW/load-use stall generation, taken-branch/jump IF/ID flush sequencing and event counters.
module hazard_sched #(
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        src2_used,
  input  logic [3:0]  id_dest,
  input  logic        id_wb_en,
  input  logic        id_mem_r_en,
  input  logic        br_taken,
  input  logic        jump_en,
  output logic        hazard_detected,
  output logic        freeze_pc,
  output logic        freeze_ifid,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned EVT_W = 16;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               exe_v_q, exe_v_d;
  logic [REG_W-1:0]   exe_dest_q, exe_dest_d;
  logic               exe_ld_q, exe_ld_d;
  logic               mem_v_q, mem_v_d;
  logic [REG_W-1:0]   mem_dest_q, mem_dest_d;
  logic [EVT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [EVT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic s1_exe_c, s2_exe_c, s1_mem_c, s2_mem_c;
  logic raw_c, hazard_c, redirect_c, issue_c;

  // Source/slot matching; R0 is hardwired zero and never creates a dependency.
  always_comb begin
    s1_exe_c = (src1 != '0) && exe_v_q && (exe_dest_q == src1);
    s2_exe_c = src2_used && (src2 != '0) && exe_v_q && (exe_dest_q == src2);
    s1_mem_c = (src1 != '0) && mem_v_q && (mem_dest_q == src1);
    s2_mem_c = src2_used && (src2 != '0) && mem_v_q && (mem_dest_q == src2);
    if (FWD_EN) begin
      raw_c = id_valid && exe_ld_q && (s1_exe_c || s2_exe_c);
    end else begin
      raw_c = id_valid && (s1_exe_c || s2_exe_c || s1_mem_c || s2_mem_c);
    end
    hazard_c   = raw_c && (state_q == RUN) && !rst;
    redirect_c = (state_q == RUN) && !rst && !hazard_c && id_valid && (br_taken || jump_en);
    issue_c    = (state_q == RUN) && id_valid && !hazard_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Flush length counts the redirect cycle itself, so FLUSH holds FLUSH_CYCLES-1 cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (redirect_c) begin
          fcnt_d  = CNT_W'(FLUSH_CYCLES - 1);
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - CNT_W'(1);
        if (fcnt_q <= CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hazard_detected = 1'b0;
    freeze_pc       = 1'b0;
    freeze_ifid     = 1'b0;
    bubble_idex     = 1'b0;
    flush_ifid      = 1'b0;
    if (hazard_c) begin
      hazard_detected = 1'b1;
      freeze_pc       = 1'b1;
      freeze_ifid     = 1'b1;
      bubble_idex     = 1'b1;
    end else if (redirect_c || ((state_q == FLUSH) && !rst)) begin
      flush_ifid = 1'b1;
    end
  end

  // Scoreboard shift and saturating event counters.
  always_comb begin
    exe_v_d     = issue_c && id_wb_en;
    exe_dest_d  = id_dest;
    exe_ld_d    = issue_c && id_mem_r_en;
    mem_v_d     = exe_v_q;
    mem_dest_d  = exe_dest_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_c && (stall_cnt_q != EVT_MAX)) begin
      stall_cnt_d = stall_cnt_q + EVT_W'(1);
    end
    if (redirect_c && (flush_cnt_q != EVT_MAX)) begin
      flush_cnt_d = flush_cnt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_v_q     <= 1'b0;
      exe_dest_q  <= '0;
      exe_ld_q    <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_dest_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_v_q     <= exe_v_d;
      exe_dest_q  <= exe_dest_d;
      exe_ld_q    <= exe_ld_d;
      mem_v_q     <= mem_v_d;
      mem_dest_q  <= mem_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: instance A forwards (FLUSH_CYCLES=2), instance B does not.
module tb_hazard_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, src2_used, id_wb_en, id_mem_r_en, br_taken, jump_en;
  logic [3:0]  src1, src2, id_dest;

  logic        a_hz, a_fpc, a_fif, a_bub, a_fl;
  logic        b_hz, b_fpc, b_fif, b_bub, b_fl;
  logic [15:0] a_stall, a_flush, b_stall, b_flush;
  logic [4:0]  a_ctl, b_ctl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign a_ctl = {a_hz, a_fpc, a_fif, a_bub, a_fl};
  assign b_ctl = {b_hz, b_fpc, b_fif, b_bub, b_fl};

  hazard_sched #(.FWD_EN(1'b1), .FLUSH_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .jump_en(jump_en),
    .hazard_detected(a_hz), .freeze_pc(a_fpc), .freeze_ifid(a_fif),
    .bubble_idex(a_bub), .flush_ifid(a_fl), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_sched #(.FWD_EN(1'b0), .FLUSH_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .jump_en(jump_en),
    .hazard_detected(b_hz), .freeze_pc(b_fpc), .freeze_ifid(b_fif),
    .bubble_idex(b_bub), .flush_ifid(b_fl), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input int s1, input int s2, input int s2u, input int d,
                       input int wb, input int ld, input int br, input int jmp);
    id_valid    = 1'(v);
    src1        = 4'(s1);
    src2        = 4'(s2);
    src2_used   = 1'(s2u);
    id_dest     = 4'(d);
    id_wb_en    = 1'(wb);
    id_mem_r_en = 1'(ld);
    br_taken    = 1'(br);
    jump_en     = 1'(jmp);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  logic [15:0] exp_cnt;

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    // Outputs gated while rst is high even with a live taken branch on the inputs
    drive(1, 1, 2, 1, 0, 0, 0, 1, 0);
    #3; chk("rst_ctl_a", 32'(a_ctl), 32'(5'b00000)); chk("rst_ctl_b", 32'(b_ctl), 32'(5'b00000));
    cyc();
    rst = 1'b0; idle();
    #3; chk("post_rst_ctl", 32'(a_ctl), 32'(5'b00000));
    chk("post_rst_stall", 32'(a_stall), 32'h0); chk("post_rst_flush", 32'(a_flush), 32'h0);
    cyc();

    // Load-use with forwarding: LD R3 ; ADD R4,R3,R5
    do_reset();
    drive(1, 1, 2, 0, 3, 1, 1, 0, 0); #3; chk("lu_ld", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 3, 5, 1, 4, 1, 0, 0, 0); #3; chk("lu_stall", 32'(a_ctl), 32'(5'b11110)); cyc();
    #3; chk("lu_issue", 32'(a_ctl), 32'(5'b00000)); chk("lu_cnt", 32'(a_stall), 32'h1); cyc();
    idle(); #3; chk("lu_cnt_hold", 32'(a_stall), 32'h1); cyc();

    // ALU-ALU with forwarding, then a load to R0 followed by an R0 reader
    do_reset();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0); #3; chk("alu_prod", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 3, 2, 1, 6, 1, 0, 0, 0); #3; chk("alu_dep", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 2, 0, 0, 1, 1, 0, 0); #3; cyc();
    drive(1, 0, 0, 1, 7, 1, 0, 0, 0); #3; chk("r0_dep", 32'(a_ctl), 32'(5'b00000));
    chk("alu_cnt", 32'(a_stall), 32'h0); cyc();

    // No forwarding: adjacent reader stalls 2, one-apart reader stalls 1
    do_reset();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0); #3; chk("nf_prod", 32'(b_ctl), 32'(5'b00000)); cyc();
    drive(1, 3, 2, 1, 7, 1, 0, 0, 0); #3; chk("nf_stall1", 32'(b_ctl), 32'(5'b11110)); cyc();
    #3; chk("nf_stall2", 32'(b_ctl), 32'(5'b11110)); cyc();
    #3; chk("nf_go", 32'(b_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0); #3; chk("nf_prod2", 32'(b_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 2, 1, 9, 1, 0, 0, 0); #3; chk("nf_indep", 32'(b_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 3, 1, 10, 1, 0, 0, 0); #3; chk("nf_stall3", 32'(b_ctl), 32'(5'b11110)); cyc();
    #3; chk("nf_go2", 32'(b_ctl), 32'(5'b00000)); chk("nf_cnt", 32'(b_stall), 32'h3); cyc();

    // Taken branch then jump, FLUSH_CYCLES=2; immediate form with unused src2 must not stall
    do_reset();
    drive(1, 1, 2, 0, 5, 1, 1, 0, 0); #3; chk("br_ld", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 5, 0, 6, 1, 0, 0, 0); #3; chk("imm_no_stall", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 2, 1, 0, 0, 0, 1, 0); #3; chk("br_f1", 32'(a_ctl), 32'(5'b00001)); cyc();
    drive(1, 1, 2, 1, 7, 1, 1, 0, 0); #3; chk("br_f2", 32'(a_ctl), 32'(5'b00001));
    chk("br_fcnt", 32'(a_flush), 32'h1); cyc();
    drive(1, 7, 2, 1, 8, 1, 0, 0, 0); #3; chk("br_run", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 1, 2, 1, 0, 0, 0, 0, 1); #3; chk("jmp_f1", 32'(a_ctl), 32'(5'b00001)); cyc();
    idle(); #3; chk("jmp_f2", 32'(a_ctl), 32'(5'b00001)); chk("jmp_fcnt", 32'(a_flush), 32'h2); cyc();
    #3; chk("jmp_run", 32'(a_ctl), 32'(5'b00000)); chk("br_no_stall", 32'(a_stall), 32'h0); cyc();

    // Branch depending on a load in EXE: stall first, flush next; rst mid-flush clears all
    do_reset();
    drive(1, 1, 2, 0, 3, 1, 1, 0, 0); #3; chk("bh_ld", 32'(a_ctl), 32'(5'b00000)); cyc();
    drive(1, 4, 3, 1, 0, 0, 0, 1, 0); #3; chk("bh_stall", 32'(a_ctl), 32'(5'b11110)); cyc();
    #3; chk("bh_flush", 32'(a_ctl), 32'(5'b00001)); chk("bh_scnt", 32'(a_stall), 32'h1);
    chk("bh_fcnt0", 32'(a_flush), 32'h0);
    rst = 1'b1; #1; chk("bh_rst_ctl", 32'(a_ctl), 32'(5'b00000)); cyc();
    rst = 1'b0; idle();
    #3; chk("bh_post_ctl", 32'(a_ctl), 32'(5'b00000));
    chk("bh_post_scnt", 32'(a_stall), 32'h0); chk("bh_post_fcnt", 32'(a_flush), 32'h0); cyc();

    // Saturation: self-dependent ADD R3,R3 without forwarding stalls 2 of every 3 cycles
    do_reset();
    drive(1, 3, 0, 0, 3, 1, 0, 0, 0);
    exp_cnt = 16'h0;
    for (int i = 0; i < 30; i++) begin
      #3; chk("sat_hz", 32'(b_hz), 32'((i % 3) != 0)); chk("sat_cnt", 32'(b_stall), 32'(exp_cnt));
      if ((i % 3) != 0) exp_cnt = exp_cnt + 16'h1;
      cyc();
    end
    #3; chk("sat_run", 32'(b_stall), 32'd20); chk("sat_hz30", 32'(b_hz), 32'h0);
    force u_b.stall_cnt_q = 16'hFFF0;
    #1;
    release u_b.stall_cnt_q;
    exp_cnt = 16'hFFF0;
    cyc();
    for (int i = 31; i < 60; i++) begin
      #3; chk("sat_hz", 32'(b_hz), 32'((i % 3) != 0)); chk("sat_cnt", 32'(b_stall), 32'(exp_cnt));
      if (((i % 3) != 0) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'h1;
      cyc();
    end
    #3; chk("sat_hold", 32'(b_stall), 32'hFFFF);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
